// File: rtl/dmem_responder.sv
// dmem_responder
// Single-port data memory with a two-stage registered read path, a one-cycle
// write acknowledge and a sticky out-of-range error flag. t_cs gates every
// state update. Memory contents are never reset.
//
// Address width comes from the DMEMADDRW macro, which defaults to 8 bits.
//
// Optional build macro: DMEM_RAW_BYPASS_EN
//   Forwards write data into the read result when a write lands on the
//   address of the read that is leaving stage 1 in the same cycle. Without it,
//   a read always returns the memory value seen at its accepting edge.

`ifndef DMEMADDRW
`define DMEMADDRW 8
`endif

module dmem_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  t_cs,
    input  logic                  ipt_wrp_to_dram_en_b,
    input  logic                  ipt_wrp_to_dram_rw,
    input  logic [`DMEMADDRW-1:0] ipt_wrp_to_dram_addr,
    input  logic [DATA_W-1:0]     ipt_alu_to_dram_wdata,
    output logic [DATA_W-1:0]     opt_dram_to_dec_rdata,
    output logic                  opt_dram_to_dec_rvalid,
    output logic                  opt_dram_to_dec_wack,
    output logic                  opt_dram_to_dec_err
);

    localparam int AW = `DMEMADDRW;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              do_write;
    logic              do_read;
    logic              in_range;
    logic [IW-1:0]     idx;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] s2_next;

    // Request decode; reset is applied inside the sequential blocks so that a
    // request presented during reset never reaches memory or the pipeline.
    assign accept   = t_cs & ~ipt_wrp_to_dram_en_b;
    assign do_write = accept & ~ipt_wrp_to_dram_rw;
    assign do_read  = accept & ipt_wrp_to_dram_rw;
    assign in_range = (32'(ipt_wrp_to_dram_addr) < 32'(DEPTH));
    assign idx      = ipt_wrp_to_dram_addr[IW-1:0];

`ifdef DMEM_RAW_BYPASS_EN
    logic [AW-1:0] s1_addr;
    logic          raw_hit;

    // A write hitting the address of the read leaving stage 1 overrides the
    // stale value that was captured at that read's accepting edge.
    assign raw_hit = s1_valid & do_write & in_range
                   & (ipt_wrp_to_dram_addr == s1_addr);
    assign s2_next = raw_hit ? ipt_alu_to_dram_wdata : s1_data;
`else
    assign s2_next = s1_data;
`endif

    // Memory array: written only by accepted in-range writes, never cleared.
    always_ff @(posedge clk) begin
        if (reset_b && do_write && in_range) begin
            mem[idx] <= ipt_alu_to_dram_wdata;
        end
    end

    // Read pipeline, write acknowledge and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            s1_valid               <= 1'b0;
            s1_data                <= '0;
`ifdef DMEM_RAW_BYPASS_EN
            s1_addr                <= '0;
`endif
            opt_dram_to_dec_rdata  <= '0;
            opt_dram_to_dec_rvalid <= 1'b0;
            opt_dram_to_dec_wack   <= 1'b0;
            opt_dram_to_dec_err    <= 1'b0;
        end else if (t_cs) begin
            s1_valid <= do_read;
            if (do_read) begin
                // Out-of-range reads still flow through with zero data so the
                // requester sees the usual two-edge response timing.
                s1_data <= in_range ? mem[idx] : '0;
`ifdef DMEM_RAW_BYPASS_EN
                s1_addr <= ipt_wrp_to_dram_addr;
`endif
            end
            opt_dram_to_dec_rvalid <= s1_valid;
            // rdata only moves when a result arrives; otherwise it holds.
            if (s1_valid) begin
                opt_dram_to_dec_rdata <= s2_next;
            end
            opt_dram_to_dec_wack <= do_write;
            if (accept && !in_range) begin
                opt_dram_to_dec_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder (DEPTH=128, 8-bit address).
// Directed vectors from a table, then randomized traffic compared against a
// scheduling reference model.

`ifndef DMEMADDRW
`define DMEMADDRW 8
`endif

module tb_dmem_responder;

    localparam int DEPTH = 128;

`ifdef DMEM_RAW_BYPASS_EN
    localparam logic [31:0] BYP = 32'h1234_5678;
`else
    localparam logic [31:0] BYP = 32'hAAAA_0000;
`endif

    logic        clk;
    logic        reset_b;
    logic        t_cs;
    logic        en_b;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wack;
    logic        err;

    int passed = 0;
    int total  = 0;

    dmem_responder #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .t_cs                   (t_cs),
        .ipt_wrp_to_dram_en_b   (en_b),
        .ipt_wrp_to_dram_rw     (rw),
        .ipt_wrp_to_dram_addr   (addr),
        .ipt_alu_to_dram_wdata  (wdata),
        .opt_dram_to_dec_rdata  (rdata),
        .opt_dram_to_dec_rvalid (rvalid),
        .opt_dram_to_dec_wack   (wack),
        .opt_dram_to_dec_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each accepted read schedules its result for the advancing edge after the
    // accepting one; results are looked up by advancing-edge number.
    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } pend_t;

    logic [31:0] mem_m [DEPTH];
    pend_t       sched [int];
    int          adv = 0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0;
    logic        m_wack = 1'b0;
    logic        m_err = 1'b0;

    task automatic model_step(input logic rb, input logic tc, input logic eb,
                              input logic r, input logic [7:0] a,
                              input logic [31:0] wd);
        logic        acc;
        logic        wr;
        logic        inr;
        logic [31:0] v;
        if (!rb) begin
            sched.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_wack   = 1'b0;
            m_err    = 1'b0;
        end else if (tc) begin
            adv++;
            acc = !eb;
            wr  = acc && !r;
            inr = (int'(a) < DEPTH);
            if (sched.exists(adv)) begin
                v = sched[adv].d;
`ifdef DMEM_RAW_BYPASS_EN
                if (wr && inr && a == sched[adv].a) v = wd;
`endif
                m_rdata  = v;
                m_rvalid = 1'b1;
                sched.delete(adv);
            end else begin
                m_rvalid = 1'b0;
            end
            m_wack = wr;
            if (wr && inr) mem_m[a[6:0]] = wd;
            if (acc && r) begin
                sched[adv + 1] = '{a: a, d: (inr ? mem_m[a[6:0]] : 32'h0)};
            end
            if (acc && !inr) m_err = 1'b1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rb, input logic tc, input logic eb,
                         input logic r, input logic [7:0] a,
                         input logic [31:0] wd);
        reset_b = rb;
        t_cs    = tc;
        en_b    = eb;
        rw      = r;
        addr    = a;
        wdata   = wd;
        model_step(rb, tc, eb, r, a, wd);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rb, tc, eb, r;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_wk, e_er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rb, logic tc, logic eb, logic r,
                                logic [7:0] a, logic [31:0] wd, logic e_rv,
                                logic [31:0] e_rd, logic e_wk, logic e_er);
        vec_t v;
        v.rb = rb; v.tc = tc; v.eb = eb; v.r = r; v.a = a; v.wd = wd;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_wk = e_wk; v.e_er = e_er;
        return v;
    endfunction

    initial begin
        reset_b = 1'b0; t_cs = 1'b1; en_b = 1'b1; rw = 1'b1;
        addr = '0; wdata = '0;

        // Table: rb tc en_b rw addr wdata | rvalid rdata wack err
        tbl.push_back(mk(1,1,0,0,8'h05,32'hDEADBEEF, 0,32'h0,        1,0)); // 0
        tbl.push_back(mk(1,1,0,1,8'h05,32'h0,        0,32'h0,        0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'hDEADBEEF, 0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        0,32'hDEADBEEF, 0,0));
        tbl.push_back(mk(1,1,0,0,8'h01,32'h11,       0,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(1,1,0,0,8'h02,32'h22,       0,32'hDEADBEEF, 1,0)); // 5
        tbl.push_back(mk(1,1,0,0,8'h03,32'h33,       0,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(1,1,0,1,8'h01,32'h0,        0,32'hDEADBEEF, 0,0));
        tbl.push_back(mk(1,1,0,1,8'h02,32'h0,        1,32'h11,       0,0));
        tbl.push_back(mk(1,1,0,1,8'h03,32'h0,        1,32'h22,       0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'h33,       0,0)); // 10
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        0,32'h33,       0,0));
        tbl.push_back(mk(1,1,0,0,8'h10,32'hAAAA0000, 0,32'h33,       1,0));
        tbl.push_back(mk(1,1,0,1,8'h10,32'h0,        0,32'h33,       0,0));
        tbl.push_back(mk(1,1,0,0,8'h10,32'h12345678, 1,BYP,          1,0));
        tbl.push_back(mk(1,1,0,1,8'h10,32'h0,        0,BYP,          0,0)); // 15
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'h12345678, 0,0));
        tbl.push_back(mk(1,1,0,1,8'h07,32'h0,        0,32'h12345678, 0,0));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        0,32'h12345678, 0,0));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        0,32'h12345678, 0,0));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        0,32'h12345678, 0,0)); // 20
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        1,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        1,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        0,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,1,0,0,8'h20,32'h5555AAAA, 0,32'hC0DE0007, 1,0)); // 25
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        0,32'hC0DE0007, 1,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        0,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,0,0,0,8'h20,32'h0,        0,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,1,0,1,8'h20,32'h0,        0,32'hC0DE0007, 0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'h5555AAAA, 0,0)); // 30
        tbl.push_back(mk(1,1,0,0,8'h80,32'hFFFFFFFF, 0,32'h5555AAAA, 1,1));
        tbl.push_back(mk(1,1,0,1,8'h80,32'h0,        0,32'h5555AAAA, 0,1));
        tbl.push_back(mk(1,1,0,1,8'h00,32'h0,        1,32'h0,        0,1));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'hC0DE0000, 0,1));
        tbl.push_back(mk(1,0,1,1,8'h00,32'h0,        1,32'hC0DE0000, 0,1)); // 35
        tbl.push_back(mk(1,1,0,1,8'h03,32'h0,        0,32'hC0DE0000, 0,1));
        tbl.push_back(mk(0,0,0,0,8'h03,32'h00000BAD, 0,32'h0,        0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        0,32'h0,        0,0));
        tbl.push_back(mk(1,1,0,1,8'h03,32'h0,        0,32'h0,        0,0));
        tbl.push_back(mk(1,1,1,1,8'h00,32'h0,        1,32'h33,       0,0)); // 40

        // Reset state
        drive(0, 1, 1, 1, 8'h00, 32'h0);
        drive(0, 0, 0, 1, 8'h04, 32'h0);
        chk("reset_rdata",  rdata,  32'h0);
        chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
        chk("reset_wack",   {31'h0, wack},   32'h0);
        chk("reset_err",    {31'h0, err},    32'h0);

        // Preload every word with a recognisable pattern
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 0, 0, 8'(i), 32'hC0DE0000 | 32'(i));
            chk($sformatf("preload_wack[%0d]", i), {31'h0, wack}, 32'h1);
        end
        drive(1, 1, 1, 1, 8'h00, 32'h0);
        chk("preload_idle_wack", {31'h0, wack}, 32'h0);
        chk("preload_rvalid",    {31'h0, rvalid}, 32'h0);

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rb, tbl[i].tc, tbl[i].eb, tbl[i].r, tbl[i].a, tbl[i].wd);
            chk($sformatf("row%0d_rvalid", i), {31'h0, rvalid}, {31'h0, tbl[i].e_rv});
            chk($sformatf("row%0d_rdata",  i), rdata, tbl[i].e_rd);
            chk($sformatf("row%0d_wack",   i), {31'h0, wack},   {31'h0, tbl[i].e_wk});
            chk($sformatf("row%0d_err",    i), {31'h0, err},    {31'h0, tbl[i].e_er});
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            logic        rb, tc, eb, r;
            logic [7:0]  a;
            int          sel;
            rb  = ($urandom_range(0, 49) != 0);
            tc  = ($urandom_range(0, 9) != 0);
            eb  = ($urandom_range(0, 2) == 0);
            r   = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = 8'($urandom_range(128, 255));
            else if (sel < 10) a = 8'($urandom_range(0, 3));
            else               a = 8'($urandom_range(0, 127));
            drive(rb, tc, eb, r, a, $urandom);
            chk($sformatf("rnd%0d_rvalid", c), {31'h0, rvalid}, {31'h0, m_rvalid});
            chk($sformatf("rnd%0d_rdata",  c), rdata, m_rdata);
            chk($sformatf("rnd%0d_wack",   c), {31'h0, wack},   {31'h0, m_wack});
            chk($sformatf("rnd%0d_err",    c), {31'h0, err},    {31'h0, m_err});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of implemented words; must be <= 2**`DMEMADDRW.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_b  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port t_cs  input  1  advance enable; 0 freezes all state.
REQ-006 SHALL have port ipt_wrp_to_dram_en_b  input  1  access request, active-low.
REQ-007 SHALL have port ipt_wrp_to_dram_rw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port ipt_wrp_to_dram_addr  input  `DMEMADDRW  word address.
REQ-009 SHALL have port ipt_alu_to_dram_wdata  input  DATA_W  write data, sampled with the write request.
REQ-010 SHALL have port opt_dram_to_dec_rdata  output  DATA_W  read data, registered.
REQ-011 SHALL have port opt_dram_to_dec_rvalid  output  1  rdata valid for one advancing cycle.
REQ-012 SHALL have port opt_dram_to_dec_wack  output  1  write committed, one advancing cycle.
REQ-013 SHALL have port opt_dram_to_dec_err  output  1  sticky out-of-range access flag.

Function
REQ-014 Accepted request = rising edge with reset_b=1, t_cs=1, en_b=0; nothing else is a request.
REQ-015 Write: at the accepting edge, mem[addr] <= wdata; wack=1 for the next cycle, then 0 at the following advancing edge.
REQ-016 Read stage 1: at the accepting edge, s1_data <= mem[addr], s1_addr <= addr, s1_valid <= 1; s1_valid <= 0 on advancing edges with no read.
REQ-017 Read stage 2: at the next advancing edge, rdata <= s1_data, rvalid <= s1_valid; read latency is exactly 2 advancing edges.
REQ-018 rdata SHALL hold its last value when rvalid=0.
REQ-019 Back-to-back reads SHALL stream one result per advancing cycle, in request order.
REQ-020 t_cs=0: memory, stage 1, rdata, rvalid, wack, err all hold; held rvalid/wack stay asserted until the next advancing edge.
REQ-021 en_b=1 with t_cs=1: no memory change; pipeline advances with bubbles.
REQ-022 Address >= DEPTH: write is discarded; read returns all-zero data with normal rvalid timing; err <= 1 at the accepting edge.
REQ-023 err stays 1 until reset; t_cs does not clear it.
REQ-024 Single port: at most one access per edge; rw decides read vs write.

Reset
REQ-025 reset_b=0 at a rising edge SHALL clear s1_valid, s1_data, s1_addr, rdata, rvalid, wack and err to 0, independent of t_cs.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset mid-read SHALL discard the in-flight read; no rvalid for it after reset.
REQ-028 Requests presented while reset_b=0 SHALL be ignored.

Configuration
REQ-029 Macro DMEM_RAW_BYPASS_EN SHALL select read-after-write forwarding.
REQ-030 Defined: if a write is accepted at the same edge that moves a valid stage-1 read to stage 2 and write addr == s1_addr (and < DEPTH), rdata SHALL take the write data.
REQ-031 Undefined: rdata SHALL take s1_data, i.e. the memory value at the read's accepting edge; no comparator logic is present.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x05, then read 0x05 -> wack=1 one cycle after the write; rvalid=1 and rdata=0xDEADBEEF two advancing edges after the read.
REQ-033 Reads to 0x01,0x02,0x03 on consecutive cycles (preloaded 0x11,0x22,0x33) -> rvalid=1 on three consecutive cycles with rdata 0x11,0x22,0x33.
REQ-034 Preload 0x10=0xAAAA0000; read 0x10, then next cycle write 0x10=0x12345678 -> rdata=0x12345678 with DMEM_RAW_BYPASS_EN, 0xAAAA0000 without; a later read returns 0x12345678 in both builds.
REQ-035 Read 0x07, drop t_cs for 3 cycles after the accepting edge -> rvalid stays 0 during the stall, goes 1 on the second advancing edge; a held rvalid=1 stays 1 through a stall.
REQ-036 DEPTH=128: write 0xFFFFFFFF to addr 0x80, then read 0x80 -> no memory change, rdata=0 with rvalid, err=1 and held until reset_b=0.
REQ-037 Read 0x03, assert reset_b=0 on the next edge -> rvalid, rdata, wack, err all 0 afterwards; no stale rvalid; memory at 0x03 unchanged.
